// File: rtl/apb_gpio_pkg.sv
// Shared constants for the APB GPIO peripheral: bus widths and register addresses.
package apb_gpio_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  localparam logic [ADDR_W-1:0] ADDR_DOUT  = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_DIR   = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_DIN   = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_IEN   = 4'h3;
  localparam logic [ADDR_W-1:0] ADDR_ISTAT = 4'h4;
  localparam logic [ADDR_W-1:0] ADDR_IEDGE = 4'h5;

  // Sticky status update: new events win over a same-cycle clear.
  function automatic logic [DATA_W-1:0] sticky_next(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] clr,
                                                    input logic [DATA_W-1:0] set);
    return (cur & ~clr) | set;
  endfunction
endpackage

// File: rtl/apb_gpio_sync.sv
// Multi-flop synchronizer for the asynchronous GPIO input pins.
module gpio_sync
  import apb_gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);
  logic [SYNC_STAGES-1:0][DATA_W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/apb_gpio.sv
// APB slave GPIO with programmable wait states; optional edge interrupts
// are built only when GPIO_IRQ_EN is defined.
module apb_gpio
  import apb_gpio_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  input  logic [DATA_W-1:0] gpio_in,
  output logic [DATA_W-1:0] gpio_out,
  output logic [DATA_W-1:0] gpio_oe,
  output logic              irq
);
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  logic [3:0]        r_cnt;
  logic              r_armed;
  logic [DATA_W-1:0] r_dout, r_dir, r_rdata;
  logic [DATA_W-1:0] w_din, w_rmux;
  logic              w_setup, w_access, w_commit;

  gpio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk  (PCLK),
    .i_rst_n(PRESETn),
    .i_d    (gpio_in),
    .o_q    (w_din)
  );

  assign w_setup  = PSEL & ~PENABLE;
  assign w_access = PSEL & PENABLE;
  // r_armed limits each transfer to a single completion and keeps PREADY low under reset.
  assign PREADY   = w_access & r_armed & (r_cnt == 4'd0);
  assign w_commit = PREADY & PWRITE;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt   <= 4'd0;
      r_armed <= 1'b0;
    end else if (w_setup) begin
      r_cnt   <= WS_INIT;
      r_armed <= 1'b1;
    end else if (w_access) begin
      if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      else               r_armed <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_dout <= '0;
      r_dir  <= '0;
    end else if (w_commit) begin
      if (PADDR == ADDR_DOUT) r_dout <= PWDATA;
      if (PADDR == ADDR_DIR)  r_dir  <= PWDATA;
    end
  end

  assign gpio_out = r_dout;
  assign gpio_oe  = r_dir;

`ifdef GPIO_IRQ_EN
  logic [DATA_W-1:0] r_ien, r_istat, r_iedge, r_prev;
  logic [DATA_W-1:0] w_rise, w_fall, w_set, w_clr;

  assign w_rise = w_din & ~r_prev;
  assign w_fall = ~w_din & r_prev;
  assign w_set  = ((w_rise & r_iedge) | (w_fall & ~r_iedge)) & r_ien;
  assign w_clr  = (w_commit && PADDR == ADDR_ISTAT) ? PWDATA : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ien   <= '0;
      r_istat <= '0;
      r_iedge <= '0;
      r_prev  <= '0;
    end else begin
      r_prev  <= w_din;
      r_istat <= sticky_next(r_istat, w_clr, w_set);
      if (w_commit && PADDR == ADDR_IEN)   r_ien   <= PWDATA;
      if (w_commit && PADDR == ADDR_IEDGE) r_iedge <= PWDATA;
    end
  end

  assign irq = |(r_istat & r_ien);
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    w_rmux = '0;
    case (PADDR)
      ADDR_DOUT:  w_rmux = r_dout;
      ADDR_DIR:   w_rmux = r_dir;
      ADDR_DIN:   w_rmux = w_din;
`ifdef GPIO_IRQ_EN
      ADDR_IEN:   w_rmux = r_ien;
      ADDR_ISTAT: w_rmux = r_istat;
      ADDR_IEDGE: w_rmux = r_iedge;
`endif
      default:    w_rmux = '0;
    endcase
  end

  // Read data is captured during setup so it cannot move while wait states elapse.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)     r_rdata <= '0;
    else if (w_setup) r_rdata <= w_rmux;
  end

  assign PRDATA = w_access ? r_rdata : '0;
endmodule

// File: tb/tb_apb_gpio.sv
// Self-checking bench for apb_gpio: one instance with two wait states, one with none.
module tb_apb_gpio;
  localparam int SYNC = 2;

  logic       PCLK = 1'b0, PRESETn = 1'b0;
  logic       PSEL2 = 1'b0, PSEL0 = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [3:0] PADDR = '0;
  logic [7:0] PWDATA = '0, gpio_in = '0;
  logic [7:0] prdata2, gout2, goe2, prdata0, gout0, goe0;
  logic       pready2, irq2, pready0, irq0;

  int n_vec = 0;
  int n_err = 0;

  always #5 PCLK = ~PCLK;

  apb_gpio #(.WAIT_STATES(2), .SYNC_STAGES(SYNC)) u_dut2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata2), .PREADY(pready2),
    .gpio_in(gpio_in), .gpio_out(gout2), .gpio_oe(goe2), .irq(irq2));

  apb_gpio #(.WAIT_STATES(0), .SYNC_STAGES(SYNC)) u_dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL0), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata0), .PREADY(pready0),
    .gpio_in(gpio_in), .gpio_out(gout0), .gpio_oe(goe0), .irq(irq0));

  typedef struct {
    bit         wr;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Full transfer starting at posedge+1; returns read data and number of access cycles.
  task automatic apb(input bit sel0, input bit wr, input logic [3:0] a, input logic [7:0] d,
                     output logic [7:0] rd, output int acc);
    PSEL0 = sel0; PSEL2 = ~sel0; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    acc = 0;
    rd  = '0;
    forever begin
      @(negedge PCLK);
      acc++;
      if ((sel0 ? pready0 : pready2) === 1'b1) begin
        rd = sel0 ? prdata0 : prdata2;
        break;
      end
      if (acc > 40) begin
        n_vec++; n_err++;
        $display("FAIL pready_timeout: got no PREADY after %0d cycles, expected %0d", acc, sel0 ? 1 : 3);
        break;
      end
      @(posedge PCLK); #1;
    end
    @(posedge PCLK); #1 PSEL0 = 1'b0; PSEL2 = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_wr(input bit sel0, input logic [3:0] a, input logic [7:0] d);
    logic [7:0] rd;
    int acc;
    apb(sel0, 1'b1, a, d, rd, acc);
    check("write_access_cycles", acc, sel0 ? 1 : 3);
  endtask

  task automatic do_rd(input bit sel0, input logic [3:0] a, input logic [7:0] exp, input string name);
    logic [7:0] rd;
    int acc;
    apb(sel0, 1'b0, a, '0, rd, acc);
    check(name, rd, exp);
    check("read_access_cycles", acc, sel0 ? 1 : 3);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  logic [7:0] m_dout [2];
  logic [7:0] m_dir  [2];

  initial begin
    vec_t tbl[$];

    // Reset state
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_prdata", prdata2, 8'h00);
    check("rst_pready", pready2, 1'b0);
    check("rst_gpio_out", gout2, 8'h00);
    check("rst_gpio_oe", goe2, 8'h00);
    check("rst_irq", irq2, 1'b0);
    check("rst_gpio_out0", gout0, 8'h00);
    @(posedge PCLK); #1 PRESETn = 1'b1;
    idle(2);

    // Register map vectors on the two-wait-state instance
    tbl.push_back('{1'b1, 4'h0, 8'hA5, 8'h00});
    tbl.push_back('{1'b1, 4'h1, 8'hF0, 8'h00});
    tbl.push_back('{1'b0, 4'h0, 8'h00, 8'hA5});
    tbl.push_back('{1'b0, 4'h1, 8'h00, 8'hF0});
    tbl.push_back('{1'b1, 4'hA, 8'hFF, 8'h00});
    tbl.push_back('{1'b0, 4'hA, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 4'h0, 8'h00, 8'hA5});
    tbl.push_back('{1'b0, 4'h1, 8'h00, 8'hF0});
    tbl.push_back('{1'b0, 4'h6, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 4'hF, 8'h00, 8'h00});
    tbl.push_back('{1'b1, 4'h3, 8'hFF, 8'h00});
`ifdef GPIO_IRQ_EN
    tbl.push_back('{1'b0, 4'h3, 8'h00, 8'hFF});
`else
    tbl.push_back('{1'b0, 4'h3, 8'h00, 8'h00});
`endif
    tbl.push_back('{1'b1, 4'h3, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 4'h2, 8'h00, 8'h00});
    tbl.push_back('{1'b1, 4'h0, 8'h5A, 8'h00});
    tbl.push_back('{1'b0, 4'h0, 8'h00, 8'h5A});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) begin
        do_wr(1'b0, tbl[i].a, tbl[i].d);
        @(negedge PCLK);
        if (tbl[i].a == 4'h0) check("tbl_gpio_out", gout2, tbl[i].d);
        if (tbl[i].a == 4'h1) check("tbl_gpio_oe", goe2, tbl[i].d);
        @(posedge PCLK); #1;
      end else begin
        do_rd(1'b0, tbl[i].a, tbl[i].exp, "tbl_read");
      end
    end
    @(negedge PCLK);
    check("tbl_final_out", gout2, 8'h5A);
    check("tbl_final_oe", goe2, 8'hF0);
    check("idle_prdata", prdata2, 8'h00);
    check("idle_pready", pready2, 1'b0);
    @(posedge PCLK); #1;

    // PSEL dropped mid-access: nothing commits
    PSEL2 = 1'b1; PWRITE = 1'b1; PADDR = 4'h0; PWDATA = 8'h11;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PSEL2 = 1'b0; PENABLE = 1'b0;
    idle(3);
    @(negedge PCLK);
    check("psel_drop_out", gout2, 8'h5A);
    @(posedge PCLK); #1;
    do_rd(1'b0, 4'h0, 8'h5A, "psel_drop_read");

    // Reset asserted in the middle of a write access
    PSEL2 = 1'b1; PWRITE = 1'b1; PADDR = 4'h1; PWDATA = 8'h77;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(negedge PCLK); PRESETn = 1'b0;
    #1;
    check("midrst_pready", pready2, 1'b0);
    check("midrst_prdata", prdata2, 8'h00);
    check("midrst_gpio_out", gout2, 8'h00);
    check("midrst_gpio_oe", goe2, 8'h00);
    check("midrst_irq", irq2, 1'b0);
    @(posedge PCLK); #1 PSEL2 = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1 PRESETn = 1'b1;
    idle(3);
    @(negedge PCLK);
    check("midrst_lost_oe", goe2, 8'h00);
    @(posedge PCLK); #1;
    do_rd(1'b0, 4'h1, 8'h00, "midrst_fresh_read");

    // Zero wait states: DIN read of held pins
    gpio_in = 8'h3C;
    idle(SYNC + 1);
    do_rd(1'b1, 4'h2, 8'h3C, "ws0_din");
    do_wr(1'b1, 4'h0, 8'hC3);
    do_rd(1'b1, 4'h0, 8'hC3, "ws0_dout");

`ifdef GPIO_IRQ_EN
    gpio_in = 8'h00;
    idle(4);
    do_wr(1'b1, 4'h3, 8'h01);
    do_wr(1'b1, 4'h5, 8'h01);
    idle(2);
    gpio_in = 8'h01;
    for (int k = 1; k <= SYNC + 1; k++) begin
      @(posedge PCLK);
      @(negedge PCLK);
      check("irq_latency", irq0, (k == SYNC + 1) ? 1'b1 : 1'b0);
    end
    @(posedge PCLK); #1;
    do_rd(1'b1, 4'h4, 8'h01, "istat_rise");
    do_wr(1'b1, 4'h4, 8'h01);
    @(negedge PCLK);
    check("irq_cleared", irq0, 1'b0);
    @(posedge PCLK); #1;

    // Falling edge ignored while rising is selected
    gpio_in = 8'h00;
    idle(5);
    @(negedge PCLK);
    check("fall_ignored", irq0, 1'b0);
    @(posedge PCLK); #1;

    // Rising edge lands on the same edge as a W1C of that bit
    gpio_in = 8'h01;
    idle(1);
    do_wr(1'b1, 4'h4, 8'h01);
    @(negedge PCLK);
    check("set_beats_clear_irq", irq0, 1'b1);
    @(posedge PCLK); #1;
    do_rd(1'b1, 4'h4, 8'h01, "set_beats_clear_istat");

    // Switch to falling edge: the write itself must not set anything
    do_wr(1'b1, 4'h4, 8'h01);
    do_wr(1'b1, 4'h5, 8'h00);
    idle(3);
    @(negedge PCLK);
    check("iedge_no_spurious", irq0, 1'b0);
    @(posedge PCLK); #1;
    gpio_in = 8'h00;
    idle(SYNC + 2);
    @(negedge PCLK);
    check("fall_irq", irq0, 1'b1);
    @(posedge PCLK); #1;
    do_rd(1'b1, 4'h4, 8'h01, "fall_istat");
    do_wr(1'b1, 4'h4, 8'h01);
`else
    do_wr(1'b1, 4'h3, 8'hFF);
    do_wr(1'b1, 4'h5, 8'hFF);
    gpio_in = 8'hFF;
    idle(SYNC + 2);
    gpio_in = 8'h00;
    idle(SYNC + 2);
    @(negedge PCLK);
    check("noirq_tied", irq0, 1'b0);
    @(posedge PCLK); #1;
    do_rd(1'b1, 4'h3, 8'h00, "noirq_ien");
    do_rd(1'b1, 4'h4, 8'h00, "noirq_istat");
    do_rd(1'b1, 4'h5, 8'h00, "noirq_iedge");
`endif

    // Randomized traffic against a register-level model
    for (int s = 0; s < 2; s++) begin
      m_dout[s] = 8'($urandom);
      m_dir[s]  = 8'($urandom);
      do_wr(s[0], 4'h0, m_dout[s]);
      do_wr(s[0], 4'h1, m_dir[s]);
    end
    for (int it = 0; it < 40; it++) begin
      bit         s0, w;
      logic [3:0] a;
      logic [7:0] d, exp;
      s0 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        gpio_in = 8'($urandom);
        idle(SYNC + 1);
      end
      a = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(6, 15));
      w = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if (w) begin
        do_wr(s0, a, d);
        if (a == 4'h0) m_dout[s0] = d;
        if (a == 4'h1) m_dir[s0]  = d;
        @(negedge PCLK);
        check("rnd_gpio_out", s0 ? gout0 : gout2, m_dout[s0]);
        check("rnd_gpio_oe", s0 ? goe0 : goe2, m_dir[s0]);
        @(posedge PCLK); #1;
      end else begin
        case (a)
          4'h0:    exp = m_dout[s0];
          4'h1:    exp = m_dir[s0];
          4'h2:    exp = gpio_in;
          default: exp = 8'h00;
        endcase
        do_rd(s0, a, exp, "rnd_read");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/apb_gpio.md
# apb_gpio

8-bit GPIO peripheral acting as an APB slave downstream of the APB master bridge. It decodes the bridge's 4-bit PADDR and 8-bit PWDATA/PRDATA bus and inserts programmable wait states via PREADY. Output pins are driven from a data register gated by a direction register. Input pins are synchronized and optionally edge-detected into a sticky interrupt.

## Interface
- WAIT_STATES, 1, PREADY-low cycles inserted at the start of each access phase (0..15)
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer (>=2)
- PCLK  in  1  bus clock; all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- PSEL  in  1  slave select
- PENABLE  in  1  access-phase marker
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  4  register address
- PWDATA  in  8  write data
- PRDATA  out  8  read data
- PREADY  out  1  transfer complete
- gpio_in  in  8  asynchronous input pins
- gpio_out  out  8  output data register
- gpio_oe  out  8  per-pin output enable (1 = drive)
- irq  out  1  level interrupt (tied 0 without GPIO_IRQ_EN)

## Operation
- Register map:
  - 0x0 DOUT (RW)
  - 0x1 DIR (RW, 1 = output)
  - 0x2 DIN (RO, synchronized pins)
  - 0x3 IEN (RW)
  - 0x4 ISTAT (R, write-1-to-clear)
  - 0x5 IEDGE (RW, 1 = rising, 0 = falling)
  - 0x6..0xF: read 0, writes ignored.
- Outputs:
  - gpio_out = DOUT.
  - gpio_oe = DIR.
  - DIN reflects the gpio_in synchronizer output regardless of DIR.
- Wait-state counter:
  - Loaded with WAIT_STATES in any cycle with PSEL=1, PENABLE=0 (setup).
  - Decrements each cycle with PSEL=1, PENABLE=1 while nonzero.
  - PREADY = PSEL & PENABLE & (count==0). PREADY is 0 at all other times.
- Write commit: at the PCLK edge where PSEL & PENABLE & PREADY & PWRITE. Exactly one commit per transfer.
- Read data:
  - PRDATA is the addressed register while PSEL & PENABLE, else 8'h00.
  - PRDATA is stable throughout the access phase.
  - A read has no side effects.
- Edge detection:
  - A registered copy of the synchronizer output gives per-bit rise/fall.
  - The selected edge on bit i with IEN[i]=1 sets ISTAT[i].
- irq = |(ISTAT & IEN).
- Reset: DOUT, DIR, IEN, ISTAT, IEDGE, the synchronizer, the edge register and the counter all go to 0. Consequently PRDATA=0, PREADY=0, gpio_out=0, gpio_oe=0, irq=0.

## Timing
- Transfer length: setup 1 cycle + access WAIT_STATES+1 cycles.
- WAIT_STATES=0 gives PREADY=1 in the first access cycle.
- Back-to-back transfers (setup directly after access) reload the counter. There is no idle cycle requirement.
- Write-to-pin latency: gpio_out/gpio_oe change on the commit edge itself, visible the cycle after it.
- Pin-to-DIN latency: SYNC_STAGES cycles.
- Pin-to-ISTAT latency: SYNC_STAGES+1 cycles. irq asserts in the same cycle as the ISTAT bit.
- ISTAT set and W1C of the same bit on the same edge: set wins and the bit stays 1.
- A write to IEDGE takes effect on the next edge comparison. No spurious ISTAT set is caused by the write itself.
- PSEL dropped mid-access (protocol violation): the counter holds its value and no write commits.
- PRESETn asserted mid-transfer: immediate clear. The pending write is lost. After release, the next setup starts a fresh transfer.

## Configuration
- GPIO_IRQ_EN defined:
  - IEN, ISTAT, IEDGE, edge register and irq logic are present as specified.
- Not defined:
  - Addresses 0x3–0x5 read 0 and ignore writes.
  - irq is tied 0.
  - No edge register is built.
  - DOUT/DIR/DIN behaviour is unchanged.

## Structure
- Package apb_gpio_pkg holds:
  - address localparams ADDR_DOUT=4'h0 … ADDR_IEDGE=4'h5
  - DATA_W=8 and ADDR_W=4
- One sub-module: gpio_sync, a parameterized SYNC_STAGES-deep, 8-bit synchronizer with asynchronous active-low reset to 0.
- Wait-state counter, register file and edge detect live in the top level.

## Test plan
- Reset with PRESETn=0 mid-access -> PRDATA=0, PREADY=0, gpio_out=0, gpio_oe=0, irq=0 immediately. A write in flight is not committed.
- WAIT_STATES=2, write 8'hA5 to 0x0, then 8'hF0 to 0x1 -> PREADY high on 3rd access cycle of each write. gpio_out=8'hA5, gpio_oe=8'hF0 the cycle after commit. Readback of 0x0 returns 8'hA5.
- WAIT_STATES=0, gpio_in=8'h3C held -> read 0x2 after >=SYNC_STAGES cycles returns 8'h3C. PREADY high in the first access cycle.
- GPIO_IRQ_EN: IEN=8'h01, IEDGE=8'h01, gpio_in[0] 0->1 -> ISTAT=8'h01 and irq=1 at SYNC_STAGES+1 cycles. Write 8'h01 to 0x4 -> irq=0.
- GPIO_IRQ_EN: rising edge on bit 0 arriving on the same edge as a W1C of bit 0 -> ISTAT[0] stays 1, irq stays 1.
- Write 8'hFF to 0xA, then read 0xA -> returns 8'h00. DOUT and DIR are unchanged.
